// File: rtl/montgomery_mul_pipe.sv
// Multi-lane, three-stage pipelined Montgomery multiplier: out = a*b*2^-W mod Q.
// All lanes share a single valid/ready handshake and a sideband tag.
module montgomery_mul_pipe #(
   parameter int W     = 12,
   parameter int Q     = 3329,
   parameter int QINV  = 3327,
   parameter int LANES = 1,
   parameter int TAGW  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LANES*W-1:0]   in_a,
   input  logic [LANES*W-1:0]   in_b,
   input  logic [TAGW-1:0]      in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANES*W-1:0]   out_data,
   output logic [TAGW-1:0]      out_tag
);

   localparam logic [W-1:0]   QINV_W = W'(QINV);
   localparam logic [2*W:0]   Q_S    = (2*W+1)'(Q);
   localparam logic [W:0]     Q_U    = (W+1)'(Q);

   // Handshake: a beat moves on a rising edge only when valid && ready are both
   // high. The whole pipeline advances together whenever the output register is
   // empty or being taken, so in_ready is combinational from out_valid/out_ready.
   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   logic                          s1_valid, s2_valid;
   logic [TAGW-1:0]               s1_tag, s2_tag;
   logic [LANES-1:0][2*W-1:0]     s1_p, s2_p;
   logic [LANES-1:0][W-1:0]       s2_m;
   logic [LANES-1:0][W-1:0]       res_q;

   logic [LANES-1:0][2*W-1:0]     p_d;
   logic [LANES-1:0][W-1:0]       m_d;
   logic [LANES-1:0][W:0]         u_d;
   logic [LANES-1:0][W-1:0]       r_d;

   always_comb begin
      p_d = '0;
      m_d = '0;
      u_d = '0;
      r_d = '0;
      for (int i = 0; i < LANES; i++) begin
         p_d[i] = {{W{1'b0}}, in_a[i*W +: W]} * {{W{1'b0}}, in_b[i*W +: W]};
         m_d[i] = s1_p[i][W-1:0] * QINV_W;
         // p + m*Q has all-zero low W bits, so the shift is an exact division by R.
         u_d[i] = (W+1)'(({1'b0, s2_p[i]} + {{(W+1){1'b0}}, s2_m[i]} * Q_S) >> W);
         r_d[i] = (u_d[i] < Q_U) ? u_d[i][W-1:0] : W'(u_d[i] - Q_U);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_tag    <= '0;
         s1_p      <= '0;
         s2_valid  <= 1'b0;
         s2_tag    <= '0;
         s2_p      <= '0;
         s2_m      <= '0;
         out_valid <= 1'b0;
         out_tag   <= '0;
         res_q     <= '0;
      end else if (en) begin
         s1_valid  <= in_valid;
         s1_tag    <= in_tag;
         s1_p      <= p_d;
         s2_valid  <= s1_valid;
         s2_tag    <= s1_tag;
         s2_p      <= s1_p;
         s2_m      <= m_d;
         out_valid <= s2_valid;
         out_tag   <= s2_tag;
         res_q     <= r_d;
      end
   end

   assign out_data = res_q;

endmodule

// File: tb/tb_montgomery_mul_pipe.sv
// Bench for montgomery_mul_pipe: directed Kyber vectors, random streaming,
// backpressure, mid-flight reset, and a LANES=4 / Falcon-modulus parameter sweep.
module tb_montgomery_mul_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Default Kyber, single lane
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [11:0] in_a, in_b, out_data;
   logic [3:0]  in_tag, out_tag;

   // Kyber, four lanes
   logic        in_valid4, in_ready4, out_valid4, out_ready4;
   logic [47:0] in_a4, in_b4, out_data4;
   logic [3:0]  in_tag4, out_tag4;

   // Falcon modulus, W=16
   logic        in_valid_f, in_ready_f, out_valid_f, out_ready_f;
   logic [15:0] in_a_f, in_b_f, out_data_f;
   logic [3:0]  in_tag_f, out_tag_f;

   montgomery_mul_pipe dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
   );

   montgomery_mul_pipe #(.LANES(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4), .in_tag(in_tag4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_tag(out_tag4)
   );

   montgomery_mul_pipe #(.W(16), .Q(12289), .QINV(12287)) dut_f (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_f), .in_ready(in_ready_f), .in_a(in_a_f), .in_b(in_b_f), .in_tag(in_tag_f),
      .out_valid(out_valid_f), .out_ready(out_ready_f), .out_data(out_data_f), .out_tag(out_tag_f)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int chk_lat = 0;
   longint rinv_k, rinv_f;

   logic [11:0] exp_d[$];
   logic [3:0]  exp_t[$];
   int          exp_c[$];

   logic        was_stalled = 1'b0;
   logic [11:0] prev_d;
   logic [3:0]  prev_t;

   // Reference: R^-1 found by brute-force search, result = a*b*R^-1 mod q.
   function automatic longint find_rinv(longint q, int w);
      longint r = 0;
      for (longint x = 1; x < q; x++)
         if (((x << w) % q) == 1) r = x;
      return r;
   endfunction

   function automatic longint mont(longint a, longint b, longint q, longint rinv);
      return (((a * b) % q) * rinv) % q;
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
      end
   endtask

   // One cycle on the Kyber single-lane DUT. exp_over < 0 selects the model.
   task automatic step(input logic iv, input logic [11:0] a, input logic [11:0] b,
                       input logic [3:0] tag, input logic ordy, input int exp_over,
                       output logic acc);
      @(negedge clk);
      in_valid = iv; in_a = a; in_b = b; in_tag = tag; out_ready = ordy;
      #1;
      cyc++;
      chk("in_ready_rule", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
      if (was_stalled) begin
         chk("stall_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_data", {20'b0, out_data}, {20'b0, prev_d});
         chk("stall_tag", {28'b0, out_tag}, {28'b0, prev_t});
      end
      if (out_valid && out_ready) begin
         total++;
         assert (exp_d.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_beat: observed data=%0d tag=%0d expected no beat", out_data, out_tag);
         end
         if (exp_d.size() != 0) begin
            logic [11:0] ed;
            logic [3:0]  et;
            int          ec;
            ed = exp_d.pop_front();
            et = exp_t.pop_front();
            ec = exp_c.pop_front();
            chk("result_data", {20'b0, out_data}, {20'b0, ed});
            chk("result_tag", {28'b0, out_tag}, {28'b0, et});
            if (chk_lat != 0) chk("latency", cyc - ec, 32'd3);
         end
      end
      was_stalled = out_valid && !out_ready;
      prev_d = out_data;
      prev_t = out_tag;
      acc = iv && in_ready;
      if (acc) begin
         exp_d.push_back((exp_over < 0) ? 12'(mont(a, b, 3329, rinv_k)) : 12'(exp_over));
         exp_t.push_back(tag);
         exp_c.push_back(cyc);
      end
   endtask

   task automatic drain();
      logic acc;
      for (int g = 0; g < 60 && exp_d.size() > 0; g++)
         step(1'b0, 12'd0, 12'd0, 4'd0, 1'b1, -1, acc);
      chk("drain_empty", exp_d.size(), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        acc;
      logic [11:0] a, b;
      logic [3:0]  tag;
      int          lat;
      longint      e4[4];
      longint      ef;

      rst = 1'b1;
      in_valid = 0; in_a = 0; in_b = 0; in_tag = 0; out_ready = 0;
      in_valid4 = 0; in_a4 = 0; in_b4 = 0; in_tag4 = 0; out_ready4 = 1;
      in_valid_f = 0; in_a_f = 0; in_b_f = 0; in_tag_f = 0; out_ready_f = 1;
      rinv_k = find_rinv(3329, 12);
      rinv_f = find_rinv(12289, 16);

      // Reset / idle
      @(negedge clk);
      chk("rst_hold_valid", {31'b0, out_valid}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_data", {20'b0, out_data}, 32'd0);
      chk("rst_out_tag", {28'b0, out_tag}, 32'd0);
      @(negedge clk);
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

      // Kyber directed vectors
      chk_lat = 1;
      step(1'b1, 12'd1,    12'd1,    4'd5, 1'b1, 2704, acc);
      step(1'b1, 12'd3328, 12'd3328, 4'd6, 1'b1, 2704, acc);
      step(1'b1, 12'd767,  12'd1000, 4'd7, 1'b1, 1000, acc);
      step(1'b1, 12'd0,    12'd3000, 4'd8, 1'b1, 0,    acc);
      drain();

      // Back-to-back random stream
      for (int n = 0; n < 1000; n++) begin
         a = 12'($urandom_range(0, 3328));
         b = 12'($urandom_range(0, 3328));
         step(1'b1, a, b, 4'(n), 1'b1, -1, acc);
         if (acc == 1'b0) chk("stream_accept", {31'b0, acc}, 32'd1);
      end
      drain();

      // Backpressure: random out_ready with a forced 5-cycle low run
      chk_lat = 0;
      begin
         int idx = 0;
         int j = 0;
         logic ordy;
         a = 12'($urandom_range(0, 3328));
         b = 12'($urandom_range(0, 3328));
         while (idx < 20 && j < 400) begin
            ordy = (j >= 6 && j < 11) ? 1'b0 : 1'($urandom_range(0, 1));
            step(1'b1, a, b, 4'(idx + 3), ordy, -1, acc);
            if (acc) begin
               idx++;
               a = 12'($urandom_range(0, 3328));
               b = 12'($urandom_range(0, 3328));
            end
            j++;
         end
         chk("bp_all_accepted", idx, 32'd20);
      end
      drain();

      // Reset while three beats are in flight
      chk_lat = 1;
      for (int n = 0; n < 3; n++)
         step(1'b1, 12'(n + 11), 12'(n + 22), 4'(n + 9), 1'b1, -1, acc);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_data", {20'b0, out_data}, 32'd0);
      exp_d.delete(); exp_t.delete(); exp_c.delete();
      was_stalled = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 8; n++)
         step(1'b0, 12'd0, 12'd0, 4'd0, 1'b1, -1, acc);

      // Four lanes, distinct random operands per lane
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         in_valid4 = 1'b1;
         in_tag4 = 4'(n);
         for (int l = 0; l < 4; l++) begin
            a = 12'($urandom_range(0, 3328));
            b = 12'($urandom_range(0, 3328));
            in_a4[l*12 +: 12] = a;
            in_b4[l*12 +: 12] = b;
            e4[l] = mont(a, b, 3329, rinv_k);
         end
         lat = 0;
         for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            in_valid4 = 1'b0;
            #1;
            if (out_valid4) begin lat = t; break; end
         end
         chk("lanes4_latency", lat, 32'd3);
         chk("lanes4_tag", {28'b0, out_tag4}, n % 16);
         for (int l = 0; l < 4; l++)
            chk($sformatf("lanes4_data%0d", l), {20'b0, out_data4[l*12 +: 12]}, 32'(e4[l]));
      end

      // Falcon modulus: a=1,b=1 first, then random operands
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         in_valid_f = 1'b1;
         in_tag_f = 4'(n + 1);
         in_a_f = (n == 0) ? 16'd1 : 16'($urandom_range(0, 12288));
         in_b_f = (n == 0) ? 16'd1 : 16'($urandom_range(0, 12288));
         ef = mont(in_a_f, in_b_f, 12289, rinv_f);
         lat = 0;
         for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            in_valid_f = 1'b0;
            #1;
            if (out_valid_f) begin lat = t; break; end
         end
         chk("falcon_latency", lat, 32'd3);
         chk("falcon_data", {16'b0, out_data_f}, 32'(ef));
         chk("falcon_tag", {28'b0, out_tag_f}, n + 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
